// File: rtl/awg_pkg.sv
// ============================================================================
// awg_pkg : shared state encoding, width defaults and LFSR constants for the
//           phase accumulator slice.                        rev 1.0
// ============================================================================
`default_nettype none

package awg_pkg;

   localparam int ACC_W_DEF      = 32;
   localparam int OUT_W_DEF      = 14;
   localparam int FREQ_W_DEF     = 14;
   localparam int PHASE_W_DEF    = 8;
   localparam int FREQ_SHIFT_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// lfsr16 : 16-bit Galois LFSR with synchronous seed load and step enable.
//          Used only for phase dither.                      rev 1.0
// ============================================================================
`default_nettype none

module lfsr16
   import awg_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   input  logic        seed,
   output logic [15:0] lfsr_state
);

   logic [15:0] lfsr_r;

   always_ff @(posedge clk) begin
      if (!rst_n || seed) begin
         lfsr_r <= LFSR_SEED;
      end else if (step) begin
         lfsr_r <= lfsr_next(lfsr_r);
      end
   end

   assign lfsr_state = lfsr_r;

endmodule

`default_nettype wire

// File: rtl/phase_acc.sv
// ============================================================================
// phase_acc : NCO phase accumulator producing the phase count for the
//             waveform stages; freq/phase updates applied at a wrap.
//             Optional dither: define PHASE_DITHER_EN.       rev 1.0
// ============================================================================
`default_nettype none

module phase_acc
   import awg_pkg::*;
#(
   parameter int ACC_W      = ACC_W_DEF,
   parameter int OUT_W      = OUT_W_DEF,
   parameter int FREQ_W     = FREQ_W_DEF,
   parameter int PHASE_W    = PHASE_W_DEF,
   parameter int FREQ_SHIFT = FREQ_SHIFT_DEF
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [FREQ_W-1:0]  state_freq,
   input  logic [PHASE_W-1:0] state_phase,
   input  logic               upd_req,
   output logic               upd_ack,
   output logic [OUT_W-1:0]   cnt,
   output logic               cnt_valid,
   output logic               wrap
);

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   ftw_q;
   logic [ACC_W-1:0]   pend_ftw;
   logic [PHASE_W-1:0] phase_q;
   logic [PHASE_W-1:0] pend_phase;
   logic               req_q;

   logic [ACC_W-1:0]   ftw_in;
   logic [ACC_W-1:0]   acc_new;
   logic [ACC_W-1:0]   trunc_src;
   logic               carry;
   logic               req_edge;
   logic [OUT_W-1:0]   cnt_next;

   assign ftw_in          = ACC_W'(state_freq) << FREQ_SHIFT;
   assign {carry, acc_new} = {1'b0, acc} + {1'b0, ftw_q};
   assign req_edge        = upd_req & ~req_q;

`ifdef PHASE_DITHER_EN
   logic [15:0] lfsr_val;
   logic        lfsr_seed;
   logic        lfsr_step;

   assign lfsr_seed = en && (state == ST_IDLE);
   assign lfsr_step = en && (state != ST_IDLE);

   lfsr16 u_lfsr16 (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (lfsr_step),
      .seed       (lfsr_seed),
      .lfsr_state (lfsr_val)
   );

   // Dither only perturbs the truncation, never the accumulator itself
   assign trunc_src = acc_new + ACC_W'(lfsr_val);
`else
   assign trunc_src = acc_new;
`endif

   assign cnt_next = trunc_src[ACC_W-1 -: OUT_W] + (OUT_W'(phase_q) << (OUT_W - PHASE_W));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         acc        <= '0;
         ftw_q      <= '0;
         phase_q    <= '0;
         pend_ftw   <= '0;
         pend_phase <= '0;
         req_q      <= 1'b0;
         cnt        <= '0;
         cnt_valid  <= 1'b0;
         wrap       <= 1'b0;
         upd_ack    <= 1'b0;
      end else begin
         req_q   <= upd_req;
         wrap    <= 1'b0;
         upd_ack <= 1'b0;
         if (!en) begin
            state      <= ST_IDLE;
            acc        <= '0;
            pend_ftw   <= '0;
            pend_phase <= '0;
            cnt        <= '0;
            cnt_valid  <= 1'b0;
         end else begin
            case (state)
               ST_RUN, ST_PEND: begin
                  acc       <= acc_new;
                  cnt       <= cnt_next;
                  wrap      <= carry;
                  cnt_valid <= 1'b1;
                  if (state == ST_RUN) begin
                     if (req_edge) begin
                        pend_ftw   <= ftw_in;
                        pend_phase <= state_phase;
                        state      <= ST_PEND;
                     end
                  end else if (carry || (ftw_q == '0)) begin
                     // A request edge landing on the apply cycle is the latest value
                     ftw_q   <= req_edge ? ftw_in      : pend_ftw;
                     phase_q <= req_edge ? state_phase : pend_phase;
                     upd_ack <= 1'b1;
                     state   <= ST_RUN;
                  end else if (req_edge) begin
                     pend_ftw   <= ftw_in;
                     pend_phase <= state_phase;
                  end
               end
               default: begin
                  ftw_q     <= ftw_in;
                  phase_q   <= state_phase;
                  acc       <= '0;
                  cnt       <= '0;
                  cnt_valid <= 1'b0;
                  state     <= ST_RUN;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_phase_acc.sv
// ============================================================================
// tb_phase_acc : self-checking bench for phase_acc (vector table plus
//                multi-cycle update/enable sequences).      rev 1.0
// ============================================================================
`default_nettype none

module tb_phase_acc;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [13:0] state_freq;
   logic [7:0]  state_phase;
   logic        upd_req;
   logic        upd_ack;
   logic [13:0] cnt;
   logic        cnt_valid;
   logic        wrap;

   int    checks = 0;
   int    fails  = 0;
   string seg    = "init";
   int    idx    = 0;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic [13:0] freq;
      logic [7:0]  phase;
      logic        req;
      logic [13:0] cnt;
      logic        valid;
      logic        wrap;
      logic        ack;
   } vec_t;

   typedef struct {
      logic [13:0] cnt;
      logic        valid;
      logic        wrap;
      logic        ack;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[13];

   phase_acc dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .state_freq  (state_freq),
      .state_phase (state_phase),
      .upd_req     (upd_req),
      .upd_ack     (upd_ack),
      .cnt         (cnt),
      .cnt_valid   (cnt_valid),
      .wrap        (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         fails++;
         $display("FAIL %s[%0d] %s: got 0x%0h expected 0x%0h", seg, idx, name, act, exp_v);
      end
   endtask

   // Drive one cycle of inputs, queue its expected outputs, compare after the edge
   task automatic cyc(input logic r, input logic e, input logic [13:0] f,
                      input logic [7:0] p, input logic q, input logic [13:0] ecnt,
                      input logic ev, input logic ew, input logic ea);
      exp_t x;
      x.cnt = ecnt; x.valid = ev; x.wrap = ew; x.ack = ea;
      sb.push_back(x);
      rst_n       = r;
      en          = e;
      state_freq  = f;
      state_phase = p;
      upd_req     = q;
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("cnt",       int'(cnt),       int'(x.cnt));
      chk("cnt_valid", int'(cnt_valid), int'(x.valid));
      chk("wrap",      int'(wrap),      int'(x.wrap));
      chk("upd_ack",   int'(upd_ack),   int'(x.ack));
   endtask

   initial begin
      logic [13:0] ec;
      logic        ew;
      logic        ea;
      logic [13:0] f;
      logic        q;

      rst_n = 1'b0; en = 1'b0; state_freq = '0; state_phase = '0; upd_req = 1'b0;

      tbl[0]  = '{1'b0, 1'b1, 14'h2000, 8'h00, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 14'h2000, 8'h00, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 14'h2000, 8'h00, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 14'h2000, 8'h00, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 14'h2000, 8'h00, 1'b1, 14'h0008, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 14'h2000, 8'h00, 1'b1, 14'h0010, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 14'h2000, 8'h00, 1'b1, 14'h0018, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 14'h2000, 8'h40, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 14'h2000, 8'h40, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 14'h2000, 8'h40, 1'b1, 14'h1008, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 14'h2000, 8'h40, 1'b1, 14'h1010, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 14'h2000, 8'h00, 1'b1, 14'h1018, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 14'h2000, 8'h00, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0};

      @(posedge clk);
      #1;

      seg = "table";
      for (int i = 0; i < 13; i++) begin
         idx = i;
         cyc(tbl[i].rst_n, tbl[i].en, tbl[i].freq, tbl[i].phase, tbl[i].req,
             tbl[i].cnt, tbl[i].valid, tbl[i].wrap, tbl[i].ack);
      end

      // Step 8 until the wrap at valid cycle 2048; two requests, latest (0x1000) wins
      seg = "wrap_update";
      for (int k = 0; k <= 2060; k++) begin
         idx = k;
         f   = (k < 100) ? 14'h2000 : ((k < 200) ? 14'h0800 : 14'h1000);
         q   = ((k >= 100) && (k < 150)) || (k >= 200);
         ew  = (k == 2048);
         ea  = (k == 2048);
         if (k <= 2048) ec = 14'((8 * k) % 16384);
         else           ec = 14'((4 * (k - 2048)) % 16384);
         cyc(1'b1, 1'b1, f, 8'h00, q, ec, (k != 0), ew, ea);
      end

      // Zero frequency: no wrap ever, update applied the cycle after capture
      seg = "zero_freq";
      idx = -1;
      cyc(1'b1, 1'b0, 14'h0000, 8'h80, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k <= 28; k++) begin
         idx = k;
         f   = (k < 21) ? 14'h0000 : ((k < 27) ? 14'h2000 : 14'h1000);
         q   = (k >= 21) && (k < 27);
         if (k <= 22) ec = 14'h2000;
         else         ec = 14'(14'h2000 + 8 * (k - 22));
         cyc(1'b1, 1'b1, f, 8'h80, q, (k == 0) ? 14'h0000 : ec, (k != 0), 1'b0, (k == 22));
      end

      // New request puts the block in PEND, then en drops: pending discarded, no ack
      seg = "en_drop_pend";
      idx = 29;
      cyc(1'b1, 1'b1, 14'h1000, 8'h80, 1'b1, 14'(14'h2000 + 8 * 7), 1'b1, 1'b0, 1'b0);
      idx = 30;
      cyc(1'b1, 1'b0, 14'h1000, 8'h80, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0);
      idx = 31;
      cyc(1'b1, 1'b0, 14'h1000, 8'h80, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0);

      seg = "reenable";
      for (int j = 0; j <= 6; j++) begin
         idx = j;
         cyc(1'b1, 1'b1, 14'h1000, 8'h10, 1'b1,
             (j == 0) ? 14'h0000 : 14'(14'h0400 + 4 * j), (j != 0), 1'b0, 1'b0);
      end

      seg = "mid_reset";
      idx = 0;
      cyc(1'b0, 1'b1, 14'h1000, 8'h10, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0);
      idx = 1;
      cyc(1'b0, 1'b1, 14'h1000, 8'h10, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0);
      idx = 2;
      cyc(1'b1, 1'b1, 14'h1000, 8'h10, 1'b1, 14'h0000, 1'b0, 1'b0, 1'b0);
      idx = 3;
      cyc(1'b1, 1'b1, 14'h1000, 8'h10, 1'b1, 14'h0404, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/phase_acc.md
Name: phase_acc

Overview:
- Numerically-controlled phase accumulator; the stage directly upstream of the triangle/waveform generators.
- Converts the front-panel frequency and phase words into the 14-bit phase count `cnt` that the waveform stages consume.
- Frequency and phase changes are applied glitch-free, only at an accumulator wrap, under a req/ack handshake.

Parameters:
- ACC_W, 32, accumulator width.
- OUT_W, 14, output phase width. Taken from the top OUT_W bits of the accumulator.
- FREQ_W, 14, width of state_freq.
- PHASE_W, 8, width of state_phase.
- FREQ_SHIFT, 8, tuning word: ftw = state_freq << FREQ_SHIFT, zero-extended to ACC_W.

Ports:
- clk, input, 1, system clock. Everything is rising-edge.
- rst_n, input, 1, synchronous active-low reset.
- en, input, 1, run enable. Level-sensitive.
- state_freq, input, FREQ_W, frequency word.
- state_phase, input, PHASE_W, phase offset word.
- upd_req, input, 1, update request. Its rising edge is the request event.
- upd_ack, output, 1, one-cycle pulse when the pending update is applied.
- cnt, output, OUT_W, phase count to the waveform generators.
- cnt_valid, output, 1, high while cnt is live.
- wrap, output, 1, one-cycle pulse on accumulator carry-out.

Behaviour:
- Reset (rst_n low at a clk edge):
  - acc, ftw_q, phase_q and pending registers cleared to 0.
  - cnt=0, cnt_valid=0, wrap=0, upd_ack=0.
  - State IDLE. Applies identically mid-operation.
- States: IDLE, RUN, PEND.
- IDLE:
  - Outputs held at their reset values.
  - When en=1: latch ftw_q=state_freq<<FREQ_SHIFT and phase_q=state_phase, clear acc, go to RUN.
  - No upd_ack is issued for this implicit load.
- RUN/PEND, every cycle:
  - acc_new = (acc + ftw_q) mod 2^ACC_W, and acc <= acc_new.
  - cnt <= (acc_new[ACC_W-1 -: OUT_W] + (phase_q << (OUT_W-PHASE_W))) mod 2^OUT_W.
  - wrap <= carry-out of the add.
  - cnt_valid=1.
  - First valid cnt appears 1 cycle after the IDLE->RUN edge, with acc_new = ftw_q.
- Request capture:
  - upd_req is registered once; the rising edge is detected against that registered copy.
  - In RUN, a rising edge captures state_freq/state_phase into pend_ftw/pend_phase and moves to PEND.
- Applying the update (PEND):
  - On the cycle whose add produces carry-out, ftw_q/phase_q <= pending values. They take effect from the next add.
  - That cycle's cnt still uses the old phase_q.
  - upd_ack pulses that same cycle (coincident with wrap); state returns to RUN.
- Re-request while in PEND: pending values are overwritten (latest wins). Exactly one ack is issued.
- ftw_q==0 in PEND: no wrap can ever occur, so the update is applied on the next cycle with upd_ack, without needing wrap.
- en=0 in any state: next cycle goes to IDLE with outputs at reset values. Pending update is discarded with no ack. en takes priority over update.
- Request edge coinciding with the IDLE->RUN edge: ignored, because the values are loaded directly.
- Width rules:
  - All additions are unsigned and truncating.
  - Max ftw = 16383<<8 with the default parameters.

Optional Feature:
- Macro: PHASE_DITHER_EN.
- When defined:
  - Adds a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Seed 0xACE1 on reset and on every IDLE->RUN; it advances every RUN/PEND cycle.
  - The truncation source becomes (acc_new + zero-extended lfsr) mod 2^ACC_W.
  - Dither never modifies acc or wrap.
- When undefined: dither term is 0 and no LFSR logic exists.

Decomposition:
- Package awg_pkg holds:
  - the state enum (IDLE/RUN/PEND);
  - ACC_W/OUT_W/FREQ_W/PHASE_W defaults;
  - LFSR polynomial and seed constants.
- One sub-module, lfsr16 (step/seed inputs, 16-bit state output). It is instantiated only under PHASE_DITHER_EN.

Test Plan:
- Hold rst_n=0 for 3 cycles with en=1 and upd_req toggling -> cnt=0, cnt_valid=0, wrap=0, upd_ack=0 throughout. Then release: RUN begins.
- en rises with state_freq=0x2000, state_phase=0 -> cnt = 8, 16, 24, ... Step is 8 per cycle. First wrap pulse lands on valid cycle 2048, with cnt=0.
- state_freq=0x2000, state_phase=0x40 -> first cnt=0x1008, wrapping mod 2^14.
- Running at 0x2000, upd_req rises at cycle 100 with state_freq=0x1000 -> no change until the wrap at cycle 2048, where upd_ack coincides with wrap. The step is 4 from the next cycle.
- state_freq=0, state_phase=0x80 -> cnt constant 0x2000, no wrap ever. An upd_req with freq=0x2000 gives upd_ack within 2 cycles of the request edge, then the step is 8.
- en dropped while in PEND -> next cycle cnt=0, cnt_valid=0, no upd_ack. Re-enabling restarts from acc=0 with the current inputs.
